// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction ROM port, decode-side jump/stall controls,
// jump-target table write port and the registered instruction outputs.
interface fetch_unit_if #(
    parameter int unsigned D = 12,
    parameter int unsigned W = 9,
    parameter int unsigned L = 3
);
    logic         stall;
    logic         jump_req;
    logic         jump_rel;
    logic [L-1:0] lut_idx;
    logic         lut_we;
    logic [L-1:0] lut_waddr;
    logic [D-1:0] lut_wdata;
    logic [D-1:0] rom_addr;
    logic [W-1:0] rom_data;
    logic [W-1:0] instr;
    logic         instr_valid;
    logic [D-1:0] prog_ctr;
    logic         done;

    // Fetch unit side
    modport master (
        input  stall, jump_req, jump_rel, lut_idx, lut_we, lut_waddr, lut_wdata, rom_data,
        output rom_addr, instr, instr_valid, prog_ctr, done
    );

    // Decode / ROM / environment side
    modport slave (
        output stall, jump_req, jump_rel, lut_idx, lut_we, lut_waddr, lut_wdata, rom_data,
        input  rom_addr, instr, instr_valid, prog_ctr, done
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, registers ROM output into the
// instruction register, resolves table-driven jumps with a one-bubble squash
// and stops on the halt opcode.
module fetch_unit #(
    parameter int unsigned    D         = 12,
    parameter int unsigned    W         = 9,
    parameter int unsigned    L         = 3,
    parameter logic [W-1:0]   HALT_CODE = W'(9'h1FF)
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int unsigned N = 1 << L;

    typedef enum logic {RUN, HALT} state_t;

    state_t       state_q, state_d;
    logic [D-1:0] fetch_pc_q, fetch_pc_d;
    logic [W-1:0] instr_q, instr_d;
    logic [D-1:0] prog_ctr_q, prog_ctr_d;
    logic         valid_q, valid_d;
    logic         done_q, done_d;
    logic [D-1:0] lut_q [N];

    logic [D-1:0] lut_entry;
    logic [D-1:0] jump_target;
    logic         halt_seen;

    // Table read is from the registered array, so a same-cycle write is not seen.
    // Entries are D bits wide, so sign extension to D bits is the identity and
    // the relative target is a plain modulo-2^D add.
    always_comb begin
        lut_entry   = lut_q[bus.lut_idx];
        jump_target = bus.jump_rel ? D'(prog_ctr_q + lut_entry) : lut_entry;
        halt_seen   = valid_q && (instr_q == HALT_CODE);
    end

    // Next-state and next-register values for the fetch FSM
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        prog_ctr_d = prog_ctr_q;
        valid_d    = valid_q;
        done_d     = done_q;
        case (state_q)
            RUN: begin
                if (halt_seen) begin
                    state_d = HALT;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else if (!bus.stall) begin
                    instr_d    = bus.rom_data;
                    prog_ctr_d = fetch_pc_q;
                    if (valid_q && bus.jump_req) begin
                        fetch_pc_d = jump_target;
                        valid_d    = 1'b0;
                    end else begin
                        fetch_pc_d = D'(fetch_pc_q + D'(1));
                        valid_d    = 1'b1;
                    end
                end
            end
            HALT: begin
                valid_d = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Fetch state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            fetch_pc_q <= '0;
            instr_q    <= '0;
            prog_ctr_q <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
            prog_ctr_q <= prog_ctr_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    // Jump-target table, writable in every state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                lut_q[i] <= '0;
            end
        end else if (bus.lut_we) begin
            lut_q[bus.lut_waddr] <= bus.lut_wdata;
        end
    end

    assign bus.rom_addr    = fetch_pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.prog_ctr    = prog_ctr_q;
    assign bus.done        = done_q;
endmodule
